// File: rtl/quant_pkg.sv
// Shared types and constants for the quantization stream controller.
package quant_pkg;

  localparam int QUANT_CORE_LAT = 6;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} quant_ctrl_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } quant_word_t;

endpackage

// File: rtl/quant_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; power-of-2 depth, pointers wrap naturally.
// Latency: a pushed byte is readable the cycle after the push.
// Backpressure: none internally; the caller's credit scheme keeps it from overflowing.
module quant_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop))
    else $error("quant_byte_fifo overflow");
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && empty))
    else $error("quant_byte_fifo underflow");

endmodule

// File: rtl/quant_stream_ctrl.sv
// Job sequencer for the free-running quant core; packs uint8 results 4 per word (QUANT_CTRL_STATS_EN adds stat ports).
// Latency: sample accept -> byte in FIFO CORE_LAT+1 cycles; word valid the cycle after its 4th/final byte pops.
// Backpressure: in_ready withheld while FIFO+in-flight reaches FIFO_DEPTH; held word frozen while !out_ready.
module quant_stream_ctrl
  import quant_pkg::*;
#(
  parameter int CORE_LAT   = QUANT_CORE_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef QUANT_CTRL_STATS_EN
  output logic [31:0]      stat_samples,
  output logic [31:0]      stat_stalls,
`endif
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_busy,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      core_in_o,
  input  logic [7:0]       core_q_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic             out_last
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  quant_ctrl_state_e   state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, pop_left_q;
  logic [CORE_LAT-1:0] tags_q;
  quant_word_t         word_q, word_d;
  logic [2:0]          fill_q, fill_d;
  logic                word_vld_q, word_vld_d;
  logic [SUM_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [7:0]          fifo_rdata;
  logic                fifo_empty, fifo_pop, hs, word_fire, last_byte, start_acc;

  assign start_acc = (state_q == IDLE) && cfg_start;
  assign hs        = in_valid && in_ready;
  assign in_ready  = (state_q == RUN) && (remaining_q != '0) &&
                     ((SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH));
  assign core_in_o = hs ? in_data : 32'd0;
  assign word_fire = word_vld_q && out_ready;
  assign fifo_pop  = !fifo_empty && (!word_vld_q || out_ready);
  assign last_byte = (pop_left_q == LEN_W'(1));

  assign cfg_busy  = (state_q != IDLE);
  assign cfg_done  = (state_q == DONE);
  assign out_valid = word_vld_q;
  assign out_data  = word_vld_q ? word_q.data : 32'd0;
  assign out_strb  = word_vld_q ? word_q.strb : 4'd0;
  assign out_last  = word_vld_q && word_q.last;

  // Credit includes the tag leaving the pipe this cycle, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + SUM_W'(tags_q[i]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (hs && remaining_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (word_fire && word_q.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      remaining_q <= '0;
      pop_left_q  <= '0;
      tags_q      <= '0;
    end else begin
      tags_q <= {tags_q[CORE_LAT-2:0], hs};
      if (start_acc) begin
        remaining_q <= cfg_len;
        pop_left_q  <= cfg_len;
      end else begin
        if (hs)       remaining_q <= remaining_q - 1'b1;
        if (fifo_pop) pop_left_q  <= pop_left_q - 1'b1;
      end
    end
  end

  quant_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tags_q[CORE_LAT-1]),
    .wdata (core_q_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A handshaking word is retired first so a same-cycle pop lands in lane 0 of the next word.
  always_comb begin
    word_d     = word_q;
    fill_d     = fill_q;
    word_vld_d = word_vld_q;
    if (word_fire) begin
      word_d     = '0;
      fill_d     = '0;
      word_vld_d = 1'b0;
    end
    if (fifo_pop) begin
      word_d.data[{fill_d[1:0], 3'b000} +: 8] = fifo_rdata;
      word_d.strb[fill_d[1:0]]                = 1'b1;
      fill_d                                  = fill_d + 3'd1;
      if (last_byte) word_d.last = 1'b1;
      if (fill_d == 3'd4 || last_byte) word_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_q     <= '0;
      fill_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      fill_q     <= fill_d;
      word_vld_q <= word_vld_d;
    end
  end

`ifdef QUANT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn || start_acc) begin
      stat_samples <= '0;
      stat_stalls  <= '0;
    end else begin
      if (hs && stat_samples != '1) stat_samples <= stat_samples + 32'd1;
      if (state_q == RUN && in_valid && !in_ready && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quant_stream_ctrl.sv
// Bench for quant_stream_ctrl with a behavioural 6-cycle core (M=256, Z=128) and a word-level reference model.
module tb_quant_stream_ctrl;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_busy, cfg_done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [31:0]      core_in_o;
  logic [7:0]       core_q_i;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [3:0]       out_strb;
  logic             out_last;
`ifdef QUANT_CTRL_STATS_EN
  logic [31:0]      stat_samples, stat_stalls;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  int acc_cnt = 0;
  w_t got[$];
  logic        hold_prev = 1'b0;
  logic [36:0] hold_w = '0;
  logic [31:0] known [4] = '{32'h0000_0000, 32'h0100_0000, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [7:0]  core_pipe [6];

  quant_stream_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
`ifdef QUANT_CTRL_STATS_EN
    .stat_samples (stat_samples),
    .stat_stalls  (stat_stalls),
`endif
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .core_in_o    (core_in_o),
    .core_q_i     (core_q_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_strb     (out_strb),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // q = clamp(floor(x*M / 2^32) + Z, 0, 255)
  function automatic logic [7:0] quant(input logic [31:0] x);
    longint v;
    v = (longint'($signed(x)) * 256) >>> 32;
    v = v + 128;
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    core_pipe[0] <= quant(core_in_o);
    for (int i = 5; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_q_i = core_pipe[5];

  always @(negedge clk) begin
    if (rstn) begin
      if (hold_prev) begin
        checks++;
        if (!out_valid || {out_data, out_strb, out_last} !== hold_w) begin
          errors++;
          $display("FAIL stable_word: got vld=%0b %h want vld=1 %h", out_valid,
                   {out_data, out_strb, out_last}, hold_w);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_w    = {out_data, out_strb, out_last};
      if (out_valid && out_ready) begin
        got.push_back({out_data, out_strb, out_last});
        last_hs_cyc = cyc;
      end
      if (cfg_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pat: 0 random, 1 zeros, 2 spec constants. hold: out_ready low cycles at job start.
  task automatic run_job(input int len, input int pat, input int hold, input bit rnd_rdy,
                         input bit full_valid, input int hold_exp, input string name,
                         output int gb, output int stalls);
    logic [31:0] smp[$];
    w_t exp_w[$];
    w_t w;
    int db, k, guard, rg, nw;
    for (int i = 0; i < len; i++) begin
      if (pat == 1)      smp.push_back(32'd0);
      else if (pat == 2) smp.push_back(known[i % 4]);
      else               smp.push_back($urandom);
    end
    nw = (len + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int l = 0; l < 4; l++) begin
        if (wi * 4 + l < len) begin
          w.data[l*8 +: 8] = quant(smp[wi*4 + l]);
          w.strb[l]        = 1'b1;
        end
      end
      w.last = (wi == nw - 1);
      exp_w.push_back(w);
    end
    gb = got.size();
    db = done_cnt;
    stalls = 0;
    acc_cnt = 0;
    out_ready = (hold == 0);
    cfg_len = len[LEN_W-1:0];
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_len = '0;
    fork
      begin
        k = 0;
        guard = 0;
        while (k < len && guard < 3000) begin
          in_valid = full_valid || ($urandom_range(0, 3) != 0);
          in_data  = in_valid ? smp[k] : 32'd0;
          @(negedge clk);
          checks++;
          if (core_in_o !== ((in_valid && in_ready) ? in_data : 32'd0)) begin
            errors++;
            $display("FAIL %s core_in: got %h want %h", name, core_in_o,
                     (in_valid && in_ready) ? in_data : 32'd0);
          end
          if (in_valid && in_ready) begin
            k++;
            acc_cnt++;
          end else if (in_valid) begin
            stalls++;
          end
          @(posedge clk); #1;
          guard++;
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        checks++;
        if (k != len) begin
          errors++;
          $display("FAIL %s feed_timeout: accepted %0d want %0d", name, k, len);
        end
      end
      begin
        rg = 0;
        repeat (hold) @(posedge clk);
        if (hold > 0) begin
          #1;
          checks++;
          if (acc_cnt != hold_exp) begin
            errors++;
            $display("FAIL %s credit_limit: accepted %0d want %0d", name, acc_cnt, hold_exp);
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s credit_ready: got %0b want 0", name, in_ready);
          end
        end
        while (done_cnt == db && rg < 4000) begin
          out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          @(posedge clk); #1;
          rg++;
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt == db) begin
          errors++;
          $display("FAIL %s done_timeout: no cfg_done", name);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got.size() - gb != nw) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", name, got.size() - gb, nw);
    end
    for (int i = 0; i < nw && gb + i < got.size(); i++) begin
      checks++;
      if (got[gb + i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s word%0d: got %h/%h/%0b want %h/%h/%0b", name, i, got[gb+i].data,
                 got[gb+i].strb, got[gb+i].last, exp_w[i].data, exp_w[i].strb, exp_w[i].last);
      end
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - db);
    end
    if (len > 0) begin
      checks++;
      if (done_cyc != last_hs_cyc + 1) begin
        errors++;
        $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_hs_cyc + 1);
      end
    end
`ifdef QUANT_CTRL_STATS_EN
    checks++;
    if (stat_samples !== 32'(len)) begin
      errors++;
      $display("FAIL %s stat_samples: got %0d want %0d", name, stat_samples, len);
    end
    checks++;
    if (stat_stalls !== 32'(stalls)) begin
      errors++;
      $display("FAIL %s stat_stalls: got %0d want %0d", name, stat_stalls, stalls);
    end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_busy, cfg_done, in_ready, out_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {cfg_busy, cfg_done, in_ready, out_valid});
    end
    checks++;
    if ({out_data, out_strb, out_last, core_in_o} !== 69'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%0b/%h want zeros", out_data, out_strb, out_last, core_in_o);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_word();
    int gb, st;
    run_job(4, 2, 0, 1'b0, 1'b1, 0, "single", gb, st);
    checks++;
    if (got.size() <= gb || got[gb] !== {32'h00FF8180, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL single_const: got %h want %h", (got.size() > gb) ? got[gb] : '0,
               {32'h00FF8180, 4'hF, 1'b1});
    end
  endtask

  task automatic test_partial();
    int gb, st;
    run_job(6, 1, 0, 1'b0, 1'b1, 0, "partial", gb, st);
    checks++;
    if (got.size() < gb + 2 || got[gb] !== {32'h80808080, 4'hF, 1'b0} ||
        got[gb+1] !== {32'h00008080, 4'h3, 1'b1}) begin
      errors++;
      $display("FAIL partial_const: got %0d words, want 80808080/F/0 then 00008080/3/1",
               got.size() - gb);
    end
  endtask

  task automatic test_backpressure();
    int gb, st;
    // 8 credits in FIFO+pipe plus the 4 bytes the packer absorbs before its word stalls
    run_job(32, 0, 20, 1'b0, 1'b1, 12, "backpressure", gb, st);
  endtask

  task automatic test_throughput();
    int gb, st;
    run_job(64, 0, 0, 1'b0, 1'b1, 0, "throughput", gb, st);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL throughput_stalls: got %0d want 0", st);
    end
  endtask

  task automatic test_zero_len();
    int gb, db;
    gb = got.size();
    db = done_cnt;
    cfg_len = '0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({cfg_busy, cfg_done} !== 2'b11) begin
      errors++;
      $display("FAIL zero_len_done: got busy/done %b want 11", {cfg_busy, cfg_done});
    end
    @(negedge clk);
    checks++;
    if ({cfg_busy, cfg_done} !== 2'b00) begin
      errors++;
      $display("FAIL zero_len_idle: got busy/done %b want 00", {cfg_busy, cfg_done});
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got.size() != gb || done_cnt - db != 1) begin
      errors++;
      $display("FAIL zero_len_out: got %0d words %0d dones want 0 and 1", got.size() - gb, done_cnt - db);
    end
  endtask

  task automatic test_reset_midjob();
    int gb, db, st;
    cfg_len = 16'd8;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midjob_ready%0d: got %0b want 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({cfg_busy, cfg_done, in_ready, out_valid, out_data, out_strb, out_last, core_in_o} !== 73'd0) begin
      errors++;
      $display("FAIL midjob_reset_outputs: busy=%0b done=%0b rdy=%0b vld=%0b data=%h", cfg_busy,
               cfg_done, in_ready, out_valid, out_data);
    end
`ifdef QUANT_CTRL_STATS_EN
    checks++;
    if ({stat_samples, stat_stalls} !== 64'd0) begin
      errors++;
      $display("FAIL midjob_reset_stats: got %0d/%0d want 0/0", stat_samples, stat_stalls);
    end
`endif
    gb = got.size();
    db = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got.size() != gb || done_cnt != db) begin
      errors++;
      $display("FAIL midjob_stale: got %0d words %0d dones want 0 and 0", got.size() - gb, done_cnt - db);
    end
    run_job(4, 0, 0, 1'b0, 1'b1, 0, "after_reset", gb, st);
  endtask

  task automatic test_random();
    int gb, st;
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 37)), 0, 0, 1'b1, 1'b0, 0, "random", gb, st);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_partial();
    test_backpressure();
    test_throughput();
    test_zero_len();
    test_reset_midjob();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
